// File: rtl/dm_result_checker.sv
// dm_result_checker: snoops the data-memory write port during a run and keeps
// shadow copies of a result window and of the sim-end word. When the end code
// lands, or the run-phase cycle limit expires, it walks the window one word per
// cycle against a golden table. Each mismatch goes out on a valid/ready port,
// and the final verdict is reported as pass, fail or timeout.
module dm_result_checker #(
    parameter int                ADDR_W     = 14,
    parameter int                DATA_W     = 32,
    parameter int                CHECK_BASE = 0,
    parameter int                CHECK_NUM  = 64,
    parameter logic [ADDR_W-1:0] END_ADDR   = 14'h3fff,
    parameter logic [DATA_W-1:0] END_CODE   = 32'hFFFF_FFFF,
    parameter int                MAX_CYCLE  = 300000,
    localparam int               IDX_W      = (CHECK_NUM > 1) ? $clog2(CHECK_NUM) : 1,
    localparam int               CNT_W      = IDX_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                wr_en,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                gold_we,
    input  logic [IDX_W-1:0]    gold_idx,
    input  logic [DATA_W-1:0]   gold_data,
    input  logic [CNT_W-1:0]    gold_num,
    output logic                mm_valid,
    input  logic                mm_ready,
    output logic [IDX_W-1:0]    mm_idx,
    output logic [DATA_W-1:0]   mm_got,
    output logic [DATA_W-1:0]   mm_exp,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [CNT_W-1:0]    err_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int                NBYTE     = DATA_W / 8;
    localparam int                CYC_W     = $clog2(MAX_CYCLE + 1);
    localparam logic [ADDR_W:0]   WIN_LO    = (ADDR_W + 1)'(CHECK_BASE);
    localparam logic [ADDR_W:0]   WIN_SZ    = (ADDR_W + 1)'(CHECK_NUM);
    localparam logic [CYC_W-1:0]  CYC_LIMIT = CYC_W'(MAX_CYCLE);
    localparam logic [CNT_W-1:0]  NUM_MAX   = CNT_W'(CHECK_NUM);

    logic [1:0]        state;
    logic [DATA_W-1:0] shadow [CHECK_NUM];
    logic [DATA_W-1:0] gold   [CHECK_NUM];
    logic [DATA_W-1:0] end_word;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [IDX_W-1:0]  chk_idx;
    logic [CNT_W-1:0]  num_lat;

    logic              idle_like;
    logic              in_run;
    logic              in_check;
    logic              start_acc;
    logic [DATA_W-1:0] byte_mask;
    logic [ADDR_W:0]   addr_off;
    logic              win_wr;
    logic [IDX_W-1:0]  win_idx;
    logic              end_wr;
    logic [DATA_W-1:0] end_merged;
    logic              end_hit;
    logic [CYC_W-1:0]  cyc_next;
    logic              time_hit;
    logic              stall;
    logic              cmp_go;
    logic              cmp_miss;
    logic              cmp_last;
    logic [CNT_W-1:0]  num_clamped;

    // Decode the snooped write, the end-word merge and the per-cycle compare step.
    always_comb begin
        idle_like  = (state == ST_IDLE) || (state == ST_DONE);
        in_run     = (state == ST_RUN);
        in_check   = (state == ST_CHECK);
        start_acc  = idle_like && start;

        byte_mask = '0;
        for (int b = 0; b < NBYTE; b++) begin
            byte_mask[b*8 +: 8] = {8{wr_strb[b]}};
        end

        // A negative offset wraps to a large value, so one compare bounds both ends.
        addr_off = {1'b0, wr_addr} - WIN_LO;
        win_wr   = in_run && wr_en && (addr_off < WIN_SZ);
        win_idx  = addr_off[IDX_W-1:0];

        end_wr     = in_run && wr_en && (wr_addr == END_ADDR);
        end_merged = (end_word & ~byte_mask) | (wr_data & byte_mask);
        end_hit    = end_wr && (end_merged == END_CODE);

        cyc_next = cyc_cnt + CYC_W'(1);
        time_hit = in_run && (cyc_next == CYC_LIMIT);

        stall    = mm_valid && !mm_ready;
        cmp_go   = in_check && (num_lat != '0) && !stall;
        cmp_miss = cmp_go && (shadow[chk_idx] != gold[chk_idx]);
        cmp_last = (({1'b0, chk_idx} + CNT_W'(1)) == num_lat);

        num_clamped = (gold_num > NUM_MAX) ? NUM_MAX : gold_num;
    end

    // Shadow window: cleared on start, byte-merged from DM writes while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHECK_NUM; i++) begin
                shadow[i] <= '0;
            end
        end else if (start_acc) begin
            for (int i = 0; i < CHECK_NUM; i++) begin
                shadow[i] <= '0;
            end
        end else if (win_wr) begin
            shadow[win_idx] <= (shadow[win_idx] & ~byte_mask) | (wr_data & byte_mask);
        end
    end

    // Golden table: loadable only while no run is in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHECK_NUM; i++) begin
                gold[i] <= '0;
            end
        end else if (gold_we && idle_like) begin
            gold[gold_idx] <= gold_data;
        end
    end

    // Run/check sequencing, cycle limit, error counting and the mismatch record port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            end_word <= '0;
            cyc_cnt  <= '0;
            chk_idx  <= '0;
            num_lat  <= '0;
            err_cnt  <= '0;
            timeout  <= 1'b0;
            mm_valid <= 1'b0;
            mm_idx   <= '0;
            mm_got   <= '0;
            mm_exp   <= '0;
        end else begin
            if (cmp_miss) begin
                mm_valid <= 1'b1;
                mm_idx   <= chk_idx;
                mm_got   <= shadow[chk_idx];
                mm_exp   <= gold[chk_idx];
            end else if (mm_valid && mm_ready) begin
                mm_valid <= 1'b0;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        end_word <= '0;
                        cyc_cnt  <= '0;
                        chk_idx  <= '0;
                        err_cnt  <= '0;
                        timeout  <= 1'b0;
                        num_lat  <= num_clamped;
                    end
                end
                ST_RUN: begin
                    cyc_cnt <= cyc_next;
                    if (end_wr) begin
                        end_word <= end_merged;
                    end
                    if (end_hit) begin
                        state <= ST_CHECK;
                    end else if (time_hit) begin
                        timeout <= 1'b1;
                        state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (num_lat == '0) begin
                        state <= ST_DONE;
                    end else if (cmp_go) begin
                        chk_idx <= chk_idx + IDX_W'(1);
                        if (cmp_miss) begin
                            err_cnt <= err_cnt + CNT_W'(1);
                        end
                        if (cmp_last) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done && (err_cnt == '0) && !timeout;

endmodule

// File: tb/tb_dm_result_checker.sv
// Testbench for dm_result_checker: table-driven end-to-end runs with
// hand-computed verdicts, plus directed sequences for stalls, split end-code
// writes, timeout, end-vs-timeout priority and reset during a check.
module tb_dm_result_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_strb = '0;
    logic [13:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        gold_we = 1'b0;
    logic [5:0]  gold_idx = '0;
    logic [31:0] gold_data = '0;
    logic [6:0]  gold_num = '0;
    logic        mm_valid;
    logic        mm_ready = 1'b1;
    logic [5:0]  mm_idx;
    logic [31:0] mm_got;
    logic [31:0] mm_exp;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [6:0]  err_cnt;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    typedef struct {
        logic [3:0][31:0] gold;
        logic [3:0][31:0] wdata;
        logic [3:0][3:0]  wstrb;
        logic [6:0]       num;
        logic [6:0]       exp_err;
        logic             exp_pass;
    } vec_t;

    vec_t vecs [8];

    int          rec_idx [$];
    logic [31:0] rec_got [$];
    logic [31:0] rec_exp [$];

    dm_result_checker #(.MAX_CYCLE(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .wr_en     (wr_en),
        .wr_strb   (wr_strb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .gold_we   (gold_we),
        .gold_idx  (gold_idx),
        .gold_data (gold_data),
        .gold_num  (gold_num),
        .mm_valid  (mm_valid),
        .mm_ready  (mm_ready),
        .mm_idx    (mm_idx),
        .mm_got    (mm_got),
        .mm_exp    (mm_exp),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .err_cnt   (err_cnt)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Last-resort guard so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic [31:0] g0, g1, g2, g3,
                                   input logic [31:0] d0, d1, d2, d3,
                                   input logic [15:0] strb,
                                   input logic [6:0] num, exp_err,
                                   input logic exp_pass);
        vec_t v;
        v.gold     = {g3, g2, g1, g0};
        v.wdata    = {d3, d2, d1, d0};
        v.wstrb    = strb;
        v.num      = num;
        v.exp_err  = exp_err;
        v.exp_pass = exp_pass;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [13:0] addr, input logic [31:0] data, input logic [3:0] strb);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        wr_strb = strb;
        tick();
        wr_en   = 1'b0;
        wr_strb = '0;
    endtask

    task automatic endWrite();
        applyStimulus(14'h3fff, 32'hFFFF_FFFF, 4'hF);
    endtask

    task automatic loadGold(input logic [31:0] g0, g1, g2, g3);
        logic [3:0][31:0] g;
        g = {g3, g2, g1, g0};
        for (int i = 0; i < 4; i++) begin
            gold_we   = 1'b1;
            gold_idx  = 6'(i);
            gold_data = g[i];
            tick();
        end
        gold_we = 1'b0;
    endtask

    task automatic startRun(input logic [6:0] num);
        gold_num = num;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, "_mm_valid"}, mm_valid, 0);
        checkOutput({pfx, "_mm_idx"}, mm_idx, 0);
        checkOutput({pfx, "_mm_got"}, mm_got, 0);
        checkOutput({pfx, "_mm_exp"}, mm_exp, 0);
        checkOutput({pfx, "_busy"}, busy, 0);
        checkOutput({pfx, "_done"}, done, 0);
        checkOutput({pfx, "_pass"}, pass, 0);
        checkOutput({pfx, "_timeout"}, timeout, 0);
        checkOutput({pfx, "_err_cnt"}, err_cnt, 0);
    endtask

    // One full run from a table entry: load, start, write, end code, drain, verdict.
    task automatic runVector(input int n, input vec_t v);
        int          k;
        int          lat_exp;
        int          e_idx [$];
        logic [31:0] e_got [$];
        logic [31:0] e_exp [$];
        logic [31:0] sh;

        for (int i = 0; i < 4; i++) begin
            sh = '0;
            for (int b = 0; b < 4; b++) begin
                if (v.wstrb[i][b]) sh[b*8 +: 8] = v.wdata[i][b*8 +: 8];
            end
            if (i < int'(v.num) && sh != v.gold[i]) begin
                e_idx.push_back(i);
                e_got.push_back(sh);
                e_exp.push_back(v.gold[i]);
            end
        end
        lat_exp = (v.num == 0) ? 1 : ((v.num > 64) ? 64 : int'(v.num));

        mm_ready = 1'b1;
        loadGold(v.gold[0], v.gold[1], v.gold[2], v.gold[3]);
        startRun(v.num);
        checkOutput($sformatf("v%0d_busy_run", n), busy, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(14'(i), v.wdata[i], v.wstrb[i]);
        end
        endWrite();
        checkOutput($sformatf("v%0d_busy_e0", n), busy, 1);

        rec_idx.delete();
        rec_got.delete();
        rec_exp.delete();
        k = 0;
        while (!done && k < 80) begin
            tick();
            k++;
            if (mm_valid) begin
                rec_idx.push_back(int'(mm_idx));
                rec_got.push_back(mm_got);
                rec_exp.push_back(mm_exp);
            end
        end
        checkOutput($sformatf("v%0d_latency", n), 64'(k), 64'(lat_exp));
        checkOutput($sformatf("v%0d_pass", n), pass, v.exp_pass);
        checkOutput($sformatf("v%0d_err_cnt", n), err_cnt, v.exp_err);
        checkOutput($sformatf("v%0d_timeout", n), timeout, 0);
        checkOutput($sformatf("v%0d_rec_count", n), 64'(rec_idx.size()), 64'(e_idx.size()));
        for (int j = 0; j < e_idx.size() && j < rec_idx.size(); j++) begin
            checkOutput($sformatf("v%0d_rec%0d_idx", n, j), 64'(rec_idx[j]), 64'(e_idx[j]));
            checkOutput($sformatf("v%0d_rec%0d_got", n, j), rec_got[j], e_got[j]);
            checkOutput($sformatf("v%0d_rec%0d_exp", n, j), rec_exp[j], e_exp[j]);
        end
        tick();
        checkOutput($sformatf("v%0d_mm_drained", n), mm_valid, 0);
        checkOutput($sformatf("v%0d_done_hold", n), done, 1);
    endtask

    initial begin
        int k;

        vecs[0] = mkVec(1, 2, 3, 4, 1, 2, 3, 4, 16'hFFFF, 4, 0, 1);
        vecs[1] = mkVec(1, 2, 3, 4, 1, 2, 32'hDEAD, 4, 16'hFFFF, 4, 1, 0);
        vecs[2] = mkVec(1, 32'hDD, 3, 4, 1, 32'hAABB_CCDD, 3, 4, 16'hFF1F, 4, 0, 1);
        vecs[3] = mkVec(1, 2, 3, 4, 5, 6, 7, 8, 16'hFFFF, 0, 0, 1);
        vecs[4] = mkVec(1, 2, 3, 4, 1, 2, 3, 4, 16'hFFFF, 100, 0, 1);
        vecs[5] = mkVec(1, 2, 3, 4, 5, 6, 7, 8, 16'hFFFF, 4, 4, 0);
        vecs[6] = mkVec(1, 2, 3, 4, 1, 2, 3, 9, 16'hFFFF, 2, 0, 1);
        vecs[7] = mkVec(1, 2, 3, 4, 1, 2, 32'h1122_3344, 4, 16'hF6FF, 4, 1, 0);

        $display("[TB] reset");
        tick();
        tick();
        checkAllZero("reset");
        #2 rst = 1'b1;
        tick();

        $display("[TB] table vectors");
        for (int n = 0; n < 8; n++) begin
            runVector(n, vecs[n]);
        end

        $display("[TB] split end code and partial strobe");
        loadGold(1, 32'hDD, 0, 0);
        startRun(2);
        applyStimulus(14'd0, 32'd1, 4'hF);
        applyStimulus(14'd1, 32'hAABB_CCDD, 4'h1);
        applyStimulus(14'h3fff, 32'hFFFF_FFFF, 4'h3);
        tick();
        tick();
        checkOutput("split_no_hit_busy", busy, 1);
        checkOutput("split_no_hit_done", done, 0);
        applyStimulus(14'h3fff, 32'hFFFF_0000, 4'hC);
        tick();
        checkOutput("split_hit_done_early", done, 0);
        tick();
        checkOutput("split_hit_done", done, 1);
        checkOutput("split_pass", pass, 1);
        checkOutput("split_err_cnt", err_cnt, 0);

        $display("[TB] stalled mismatch port");
        loadGold(1, 2, 3, 4);
        startRun(4);
        mm_ready = 1'b0;
        applyStimulus(14'd0, 32'd9, 4'hF);
        applyStimulus(14'd1, 32'd2, 4'hF);
        applyStimulus(14'd2, 32'd9, 4'hF);
        applyStimulus(14'd3, 32'd9, 4'hF);
        endWrite();
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) begin
                applyStimulus(14'd3, 32'd4, 4'hF);
            end else begin
                tick();
            end
            checkOutput($sformatf("stall%0d_mm_valid", c), mm_valid, 1);
            checkOutput($sformatf("stall%0d_mm_idx", c), mm_idx, 0);
            checkOutput($sformatf("stall%0d_mm_got", c), mm_got, 9);
            checkOutput($sformatf("stall%0d_mm_exp", c), mm_exp, 1);
            checkOutput($sformatf("stall%0d_err_cnt", c), err_cnt, 1);
            checkOutput($sformatf("stall%0d_done", c), done, 0);
        end
        rec_idx.delete();
        rec_got.delete();
        rec_exp.delete();
        rec_idx.push_back(int'(mm_idx));
        rec_got.push_back(mm_got);
        rec_exp.push_back(mm_exp);
        mm_ready = 1'b1;
        k = 0;
        while (!(done && !mm_valid) && k < 20) begin
            tick();
            k++;
            if (mm_valid) begin
                rec_idx.push_back(int'(mm_idx));
                rec_got.push_back(mm_got);
                rec_exp.push_back(mm_exp);
            end
        end
        checkOutput("stall_drain_done", done, 1);
        checkOutput("stall_rec_count", 64'(rec_idx.size()), 3);
        if (rec_idx.size() == 3) begin
            checkOutput("stall_rec1_idx", 64'(rec_idx[1]), 2);
            checkOutput("stall_rec1_exp", rec_exp[1], 3);
            checkOutput("stall_rec2_idx", 64'(rec_idx[2]), 3);
            checkOutput("stall_rec2_got", rec_got[2], 9);
            checkOutput("stall_rec2_exp", rec_exp[2], 4);
        end
        checkOutput("stall_err_cnt", err_cnt, 3);
        checkOutput("stall_pass", pass, 0);

        $display("[TB] timeout");
        loadGold(1, 2, 3, 4);
        startRun(4);
        gold_we   = 1'b1;
        gold_idx  = 6'd0;
        gold_data = 32'h55;
        applyStimulus(14'd0, 32'd1, 4'hF);
        gold_we   = 1'b0;
        applyStimulus(14'd1, 32'd2, 4'hF);
        applyStimulus(14'd2, 32'd3, 4'hF);
        applyStimulus(14'd3, 32'd4, 4'hF);
        k = 4;
        while (!timeout && k < 150) begin
            tick();
            k++;
        end
        checkOutput("to_cycles", 64'(k), 100);
        checkOutput("to_busy", busy, 1);
        for (int c = 0; c < 4; c++) tick();
        checkOutput("to_done", done, 1);
        checkOutput("to_timeout", timeout, 1);
        checkOutput("to_err_cnt", err_cnt, 0);
        checkOutput("to_pass", pass, 0);

        $display("[TB] end hit on the timeout cycle");
        startRun(0);
        for (int c = 0; c < 99; c++) tick();
        checkOutput("tie_before_timeout", timeout, 0);
        endWrite();
        checkOutput("tie_timeout", timeout, 0);
        checkOutput("tie_busy", busy, 1);
        tick();
        checkOutput("tie_done", done, 1);
        checkOutput("tie_pass", pass, 1);

        $display("[TB] reset during check");
        loadGold(1, 2, 3, 4);
        startRun(4);
        mm_ready = 1'b0;
        endWrite();
        tick();
        tick();
        checkOutput("rst_pre_mm_valid", mm_valid, 1);
        #3 rst = 1'b0;
        #1;
        checkAllZero("rst_mid");
        #2 rst = 1'b1;
        mm_ready = 1'b1;
        tick();
        startRun(0);
        endWrite();
        checkOutput("rst_n0_done_e0", done, 0);
        tick();
        checkOutput("rst_n0_done", done, 1);
        checkOutput("rst_n0_pass", pass, 1);
        startRun(4);
        endWrite();
        k = 0;
        while (!done && k < 20) begin
            tick();
            k++;
        end
        checkOutput("rst_gold_latency", 64'(k), 4);
        checkOutput("rst_gold_cleared_pass", pass, 1);
        checkOutput("rst_gold_cleared_err", err_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/dm_result_checker.md
Name: dm_result_checker

Overview:
- Synthesizable, parametrised successor to the bench's end-of-test checking logic: snoops the data-memory write port and holds shadow copies of a result window and of a sim-end word.
- When the end code lands, or a cycle limit expires, it compares the window against a loaded golden table, one word per cycle.
- It streams mismatches out over a valid/ready port and reports pass, fail or timeout.
- Sits beside DM in the top level (emulation/FPGA builds), or behind the bench as a checker.

Parameters:
ADDR_W, 14, DM word-address width
DATA_W, 32, data width; multiple of 8
CHECK_BASE, 0, word address of first checked word
CHECK_NUM, 64, shadow/golden depth (max words checked)
END_ADDR, 14'h3fff, word address of sim-end marker
END_CODE, 32'hFFFF_FFFF, marker value that ends the run
MAX_CYCLE, 300000, run-phase cycle limit before timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  pulse: clear shadows/counters, enter RUN
wr_en  in  1  DM write strobe (snooped)
wr_strb  in  DATA_W/8  byte enables, active-high
wr_addr  in  ADDR_W  DM word address
wr_data  in  DATA_W  DM write data
gold_we  in  1  golden table write
gold_idx  in  clog2(CHECK_NUM)  golden entry index
gold_data  in  DATA_W  golden value
gold_num  in  clog2(CHECK_NUM)+1  words to check, sampled on start
mm_valid  out  1  mismatch record valid
mm_ready  in  1  consumer accepts record
mm_idx  out  clog2(CHECK_NUM)  mismatching word index
mm_got  out  DATA_W  shadow value
mm_exp  out  DATA_W  golden value
busy  out  1  state is RUN or CHECK
done  out  1  state is DONE
pass  out  1  valid when done: err_cnt==0 and no timeout
timeout  out  1  MAX_CYCLE reached before end code
err_cnt  out  clog2(CHECK_NUM)+1  mismatches found

Behaviour:
- Reset: state IDLE. All outputs 0. Shadow, end word and golden table cleared to 0. Cycle counter 0.
- FSM states: IDLE, RUN, CHECK, DONE.
  - IDLE/DONE -> RUN on start.
  - RUN -> CHECK on end hit or timeout.
  - CHECK -> DONE after last word is compared.
  - start in RUN/CHECK is ignored.
- On start:
  - Shadow and end word cleared to 0; err_cnt, timeout, cycle counter, chk_idx cleared.
  - gold_num latched; values above CHECK_NUM clamp to CHECK_NUM.
- gold_we is honoured only in IDLE/DONE; ignored in RUN/CHECK.
- Snooping, RUN only:
  - Write with wr_addr in [CHECK_BASE, CHECK_BASE+CHECK_NUM) updates shadow[wr_addr-CHECK_BASE], per enabled byte.
  - Write with wr_addr==END_ADDR merges enabled bytes into the end word.
  - If END_ADDR lies inside the window, both updates apply.
  - Writes outside RUN are ignored.
- End hit: the merged end word (stored bytes plus this write's enabled bytes) equals END_CODE at the sampling edge. FSM enters CHECK at that same edge (E0).
- Timeout: cycle counter increments every RUN cycle. When it reaches MAX_CYCLE, set timeout=1 and enter CHECK; checking still runs. If the end hit and timeout occur in the same cycle, the end hit wins (timeout=0).
- CHECK, comparing shadow[chk_idx] against gold[chk_idx]:
  - Each cycle compares one word and advances chk_idx, unless stalled.
  - Stall condition: mm_valid && !mm_ready.
  - A mismatch registers mm_valid/mm_idx/mm_got/mm_exp at the next edge and increments err_cnt.
  - mm_* hold stable while mm_valid && !mm_ready; mm_valid drops after acceptance if there is no new mismatch.
- Completion:
  - With no stalls, done=1 at edge E0+max(N,1), where N is the latched gold_num. N=0 yields DONE with err_cnt=0.
  - DONE holds until start. pass = (err_cnt==0) && !timeout.
  - The final mismatch record may still be pending in DONE; mm_valid remains until accepted.
- Reset asserted mid-RUN/CHECK: immediate return to IDLE with all state cleared, including the golden table.

Test Plan:
1. Golden[0..3]={1,2,3,4}, gold_num=4, start. Write words 0..3 with those values, then write 0xFFFFFFFF to 0x3fff with strb=4'hF. -> done 4 cycles after the end edge, pass=1, err_cnt=0, no mm_valid.
2. Same as 1, but word 2 is written as 0xDEAD with mm_ready=1. -> one record: mm_idx=2, mm_got=0xDEAD, mm_exp=3. err_cnt=1, pass=0.
3. End code written as two halves (strb=4'h3 then 4'hC); word 1 is written with strb=4'h1 only (data 0xAABBCCDD on a zeroed word). -> end hit only on the second half; shadow[1]=0x000000DD.
4. Three mismatches with mm_ready held 0 for 5 cycles. -> chk_idx frozen, mm_* stable, no records lost, err_cnt=3 after drain.
5. No end code written, with MAX_CYCLE overridden to 100. -> CHECK entered after 100 RUN cycles, timeout=1, pass=0 even when all words match.
6. rst pulled low mid-CHECK, then start with gold_num=0. -> all outputs 0 after reset; done one cycle after the end hit, pass=1.
